// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC register, word address to the combinational instruction memory, and the IF/ID
// register with stall, flush, branch redirect, out-of-range fetch fault and a count of valid fetches.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          MEM_DEPTH = 32,
  parameter logic [31:0] NOP_INSTR = 32'hE1A0_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] instructionAdress,
  input  logic [31:0] instruction,
  input  logic        stallF,
  input  logic        stallD,
  input  logic        flushD,
  input  logic        branchTaken,
  input  logic [31:0] branchTarget,
  output logic [31:0] pcF,
  output logic [31:0] instrD,
  output logic [31:0] pcPlus4D,
  output logic [31:0] pcPlus8D,
  output logic        validD,
  output logic        fetchFault,
  output logic [31:0] fetchCount
);

  localparam logic [31:0] RESET_PC_ALIGNED = RESET_PC & ~32'h3;
  localparam logic [31:0] DEPTH_W          = 32'(MEM_DEPTH);

  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [31:0] pc8_q, pc8_d;
  logic        valid_q, valid_d;
  logic [31:0] count_q, count_d;
  logic        fault;
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;

  assign instructionAdress = {2'b00, pc_q[31:2]};
  assign fault             = instructionAdress >= DEPTH_W;
  assign pc_plus4          = pc_q + 32'd4;
  assign pc_plus8          = pc_q + 32'd8;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    pc4_d   = pc4_q;
    pc8_d   = pc8_q;
    valid_d = valid_q;
    count_d = count_q;

    // A redirect must never be dropped, so it outranks the fetch stall.
    if (branchTaken) begin
      pc_d = branchTarget & ~32'h3;
    end else if (!stallF) begin
      pc_d = pc_plus4;
    end

    // The word fetched on a redirect edge is down the wrong path: squash it.
    if (flushD || branchTaken) begin
      instr_d = NOP_INSTR;
      valid_d = 1'b0;
    end else if (!stallD) begin
      instr_d = fault ? NOP_INSTR : instruction;
      pc4_d   = pc_plus4;
      pc8_d   = pc_plus8;
      valid_d = ~fault;
      if (!fault) begin
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC_ALIGNED;
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'd0;
      pc8_q   <= 32'd0;
      valid_q <= 1'b0;
      count_q <= 32'd0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      pc8_q   <= pc8_d;
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign pcF        = pc_q;
  assign instrD     = instr_q;
  assign pcPlus4D   = pc4_q;
  assign pcPlus8D   = pc8_q;
  assign validD     = valid_q;
  assign fetchFault = fault;
  assign fetchCount = count_q;

endmodule
